// File: rtl/lfsr_pkg.sv
// lfsr_pkg -- shared types and helpers for the lfsr_gen pattern generator.
//   lfsr_fsm_e : generator control states (SEEDED, RUN, RECOVER)
//   lfsr_step  : one Fibonacci shift; returns {next_state, shifted_out_bit}
//   lfsr_lock  : the lock-up state for a given polarity (all-ones XNOR, all-zeros XOR)
//   lfsr_subst : the state substituted for a lock-up (all-zeros XNOR, 1 XOR)
// All helpers work on 32-bit containers; callers keep state in the low 'width' bits.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEEDED  = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } lfsr_fsm_e;

  function automatic logic [32:0] lfsr_step(input logic [31:0] st,
                                            input logic [31:0] taps,
                                            input logic        xn,
                                            input int unsigned width);
    logic        fb;
    logic [31:0] nxt;
    fb  = (^(st & taps)) ^ xn;
    nxt = (st >> 1) | ({31'b0, fb} << (width - 1));
    return {nxt, st[0]};
  endfunction

  function automatic logic [31:0] lfsr_lock(input int unsigned width, input logic xn);
    return xn ? (32'hFFFF_FFFF >> (32 - width)) : 32'h0;
  endfunction

  function automatic logic [31:0] lfsr_subst(input logic xn);
    return xn ? 32'h0 : 32'h1;
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if -- control/data bundle of the lfsr_gen generator.
//   ENABLE, LOAD, SEED_IN          : driven by the master (user)
//   OUTDATA, BIT_OUT, OUT_VALID,
//   LOCKUP_ERR                     : driven by the slave (lfsr_gen)
//   WRAP, PERIOD_CNT               : only present when LFSR_GEN_PERIOD_EN is defined
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned STEPS = 1
) ();
  logic             ENABLE;
  logic             LOAD;
  logic [WIDTH-1:0] SEED_IN;
  logic [WIDTH-1:0] OUTDATA;
  logic [STEPS-1:0] BIT_OUT;
  logic             OUT_VALID;
  logic             LOCKUP_ERR;
`ifdef LFSR_GEN_PERIOD_EN
  logic             WRAP;
  logic [WIDTH-1:0] PERIOD_CNT;

  modport master (output ENABLE, LOAD, SEED_IN,
                  input  OUTDATA, BIT_OUT, OUT_VALID, LOCKUP_ERR, WRAP, PERIOD_CNT);
  modport slave  (input  ENABLE, LOAD, SEED_IN,
                  output OUTDATA, BIT_OUT, OUT_VALID, LOCKUP_ERR, WRAP, PERIOD_CNT);
`else
  modport master (output ENABLE, LOAD, SEED_IN,
                  input  OUTDATA, BIT_OUT, OUT_VALID, LOCKUP_ERR);
  modport slave  (input  ENABLE, LOAD, SEED_IN,
                  output OUTDATA, BIT_OUT, OUT_VALID, LOCKUP_ERR);
`endif
endinterface

// File: rtl/lfsr_step_net.sv
// lfsr_step_net -- combinational STEPS-deep unroll of lfsr_step.
//   cur_state  in  WIDTH  state before the advance
//   next_state out WIDTH  state after STEPS single-bit shifts
//   out_bits   out STEPS  out_bits[k] = state[0] before shift k
module lfsr_step_net import lfsr_pkg::*; #(
  parameter int unsigned      WIDTH = 19,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(19'h40023),
  parameter bit               XNOR  = 1'b1,
  parameter int unsigned      STEPS = 1
) (
  input  logic [WIDTH-1:0] cur_state,
  output logic [WIDTH-1:0] next_state,
  output logic [STEPS-1:0] out_bits
);

  logic [31:0] s;
  logic [32:0] r;

  always_comb begin
    s        = 32'(cur_state);
    r        = '0;
    out_bits = '0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      r           = lfsr_step(s, 32'(TAPS), XNOR, WIDTH);
      out_bits[k] = r[0];
      s           = r[32:1];
    end
    next_state = s[WIDTH-1:0];
  end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen -- parametrised Fibonacci LFSR pattern generator.
//   CLOCK  in  rising-edge clock
//   RESET  in  synchronous, active-high reset (state <= SEED)
//   bus    lfsr_gen_if.slave: ENABLE/LOAD/SEED_IN in; OUTDATA, BIT_OUT,
//          OUT_VALID, LOCKUP_ERR (and WRAP, PERIOD_CNT) out
// Optional feature: define LFSR_GEN_PERIOD_EN to add the seed-reference register,
// the advance counter PERIOD_CNT and the WRAP pulse.
// Edge priority: RESET > LOAD > lock-up recovery > ENABLE.
module lfsr_gen import lfsr_pkg::*; #(
  parameter int unsigned      WIDTH = 19,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(19'h40023),
  parameter bit               XNOR  = 1'b1,
  parameter int unsigned      STEPS = 1,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input logic       CLOCK,
  input logic       RESET,
  lfsr_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] LOCK  = WIDTH'(lfsr_lock(WIDTH, XNOR));
  localparam logic [WIDTH-1:0] SUBST = WIDTH'(lfsr_subst(XNOR));

  lfsr_fsm_e        fsm_q, fsm_d, fsm_eff;
  logic [WIDTH-1:0] state_q, state_d, step_state;
  logic [STEPS-1:0] bits_q, bits_d, step_bits;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             advance;
  logic             reseed;

  lfsr_step_net #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .XNOR  (XNOR),
    .STEPS (STEPS)
  ) u_step (
    .cur_state  (state_q),
    .next_state (step_state),
    .out_bits   (step_bits)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      fsm_q   <= SEEDED;
      state_q <= SEED;
      bits_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      bits_q  <= bits_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // RECOVER is transient: it is entered whenever the held state is the lock
  // value, so the register itself only ever holds SEEDED or RUN.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    bits_d  = bits_q;
    valid_d = valid_q;
    err_d   = err_q;
    advance = 1'b0;
    reseed  = 1'b0;
    fsm_eff = (state_q == LOCK) ? RECOVER : fsm_q;

    if (bus.LOAD) begin
      state_d = (bus.SEED_IN == LOCK) ? SUBST : bus.SEED_IN;
      err_d   = (bus.SEED_IN == LOCK);
      bits_d  = '0;
      valid_d = 1'b0;
      fsm_d   = SEEDED;
      reseed  = 1'b1;
    end else begin
      unique case (fsm_eff)
        RECOVER: begin
          state_d = SUBST;
          err_d   = 1'b1;
          bits_d  = '0;
          valid_d = 1'b0;
          fsm_d   = SEEDED;
          reseed  = 1'b1;
        end
        SEEDED: begin
          if (bus.ENABLE) begin
            state_d = step_state;
            bits_d  = step_bits;
            fsm_d   = RUN;
            advance = 1'b1;
          end
        end
        RUN: begin
          if (bus.ENABLE) begin
            state_d = step_state;
            bits_d  = step_bits;
            valid_d = 1'b1;
            advance = 1'b1;
          end
        end
        default: begin
          fsm_d = SEEDED;
        end
      endcase
    end
  end

  assign bus.OUTDATA    = state_q;
  assign bus.BIT_OUT    = bits_q;
  assign bus.OUT_VALID  = valid_q;
  assign bus.LOCKUP_ERR = err_q;

`ifdef LFSR_GEN_PERIOD_EN
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cnt_q;
  logic             wrap_q;

  // Any reseed (LOAD or recovery) captures the new starting state as reference.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ref_q  <= SEED;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (reseed) begin
        ref_q <= state_d;
        cnt_q <= '0;
      end else if (advance) begin
        cnt_q  <= cnt_q + WIDTH'(STEPS);
        wrap_q <= (state_d == ref_q);
      end
    end
  end

  assign bus.WRAP       = wrap_q;
  assign bus.PERIOD_CNT = cnt_q;
`else
  // Advance/reseed strobes only feed the period logic.
  logic unused_strobes;
  assign unused_strobes = advance ^ reseed;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen -- directed self-checking bench for lfsr_gen.
// Default 19-bit instance driven from a vector table plus lock-up/reset sequence;
// a STEPS=4 instance checked against a single-step reference model; with
// LFSR_GEN_PERIOD_EN defined, a 4-bit instance checks WRAP and PERIOD_CNT.
module tb_lfsr_gen;

  logic CLOCK;
  logic RESET;
  int   n_chk;
  int   n_fail;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  lfsr_gen_if #(.WIDTH(19), .STEPS(1)) if0 ();
  lfsr_gen_if #(.WIDTH(19), .STEPS(4)) if4 ();

  lfsr_gen #(.WIDTH(19), .TAPS(19'h40023), .XNOR(1'b1), .STEPS(1), .SEED(19'h00001))
    u0 (.CLOCK(CLOCK), .RESET(RESET), .bus(if0));

  lfsr_gen #(.WIDTH(19), .TAPS(19'h40023), .XNOR(1'b1), .STEPS(4), .SEED(19'h00001))
    u4 (.CLOCK(CLOCK), .RESET(RESET), .bus(if4));

`ifdef LFSR_GEN_PERIOD_EN
  lfsr_gen_if #(.WIDTH(4), .STEPS(1)) if5 ();
  lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .XNOR(1'b0), .STEPS(1), .SEED(4'h1))
    u5 (.CLOCK(CLOCK), .RESET(RESET), .bus(if5));
`endif

  typedef struct {
    logic        rst;
    logic        en;
    logic        ld;
    logic [18:0] seed;
    logic [18:0] out;
    logic        bit0;
    logic        valid;
    logic        err;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [18:0] ms;
    logic [3:0]  mb;
    logic        en;
    logic        fb;

    n_chk  = 0;
    n_fail = 0;
    RESET  = 1'b1;
    if0.ENABLE = 1'b0; if0.LOAD = 1'b0; if0.SEED_IN = '0;
    if4.ENABLE = 1'b0; if4.LOAD = 1'b0; if4.SEED_IN = '0;
`ifdef LFSR_GEN_PERIOD_EN
    if5.ENABLE = 1'b0; if5.LOAD = 1'b0; if5.SEED_IN = '0;
`endif

    //           rst   en    ld    seed       out        bit   valid err
    vt[0]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 19'h00001, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 19'h00000, 19'h00000, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 19'h00000, 19'h40000, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 19'h00000, 19'h40000, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 19'h00000, 19'h20000, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 19'h7FFFF, 19'h00000, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 19'h00000, 19'h40000, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 19'h00005, 19'h00005, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 19'h00000, 19'h00002, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 19'h00000, 19'h00001, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b1, 19'h12345, 19'h12345, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 19'h00000, 19'h091A2, 1'b1, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 19'h00000, 19'h00001, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      RESET       = vt[i].rst;
      if0.ENABLE  = vt[i].en;
      if0.LOAD    = vt[i].ld;
      if0.SEED_IN = vt[i].seed;
      tick();
      check($sformatf("vec%0d OUTDATA", i),    32'(if0.OUTDATA),    32'(vt[i].out));
      check($sformatf("vec%0d BIT_OUT", i),    32'(if0.BIT_OUT),    32'(vt[i].bit0));
      check($sformatf("vec%0d OUT_VALID", i),  32'(if0.OUT_VALID),  32'(vt[i].valid));
      check($sformatf("vec%0d LOCKUP_ERR", i), 32'(if0.LOCKUP_ERR), 32'(vt[i].err));
    end
    RESET = 1'b0; if0.ENABLE = 1'b0; if0.LOAD = 1'b0; if0.SEED_IN = '0;

    // Corrupted state mid-run: recovery wins over ENABLE, then reset mid-run.
    RESET = 1'b1; tick(); RESET = 1'b0;
    if0.ENABLE = 1'b1;
    tick(); tick(); tick();
    check("run OUTDATA", 32'(if0.OUTDATA), 32'h20000);
    check("run OUT_VALID", 32'(if0.OUT_VALID), 32'h1);
    force u0.state_q = 19'h7FFFF;
    #2;
    release u0.state_q;
    tick();
    check("lock OUTDATA", 32'(if0.OUTDATA), 32'h00000);
    check("lock LOCKUP_ERR", 32'(if0.LOCKUP_ERR), 32'h1);
    check("lock OUT_VALID", 32'(if0.OUT_VALID), 32'h0);
    check("lock BIT_OUT", 32'(if0.BIT_OUT), 32'h0);
    tick();
    check("post-lock OUTDATA", 32'(if0.OUTDATA), 32'h40000);
    check("post-lock OUT_VALID", 32'(if0.OUT_VALID), 32'h0);
    check("post-lock LOCKUP_ERR", 32'(if0.LOCKUP_ERR), 32'h1);
    RESET = 1'b1;
    tick();
    check("midrun reset OUTDATA", 32'(if0.OUTDATA), 32'h00001);
    check("midrun reset LOCKUP_ERR", 32'(if0.LOCKUP_ERR), 32'h0);
    RESET = 1'b0; if0.ENABLE = 1'b0;

    // STEPS=4 against four single-step reference shifts per enabled cycle.
    RESET = 1'b1; tick(); RESET = 1'b0;
    ms = 19'h00001; mb = 4'h0;
    check("x4 reset OUTDATA", 32'(if4.OUTDATA), 32'(ms));
    check("x4 reset BIT_OUT", 32'(if4.BIT_OUT), 32'(mb));
    for (int c = 0; c < 1000; c++) begin
      en = 1'($urandom_range(0, 1));
      if4.ENABLE = en;
      tick();
      if (en) begin
        for (int k = 0; k < 4; k++) begin
          mb[k] = ms[0];
          fb    = ~(^(ms & 19'h40023));
          ms    = {fb, ms[18:1]};
        end
      end
      check($sformatf("x4 c%0d OUTDATA", c), 32'(if4.OUTDATA), 32'(ms));
      check($sformatf("x4 c%0d BIT_OUT", c), 32'(if4.BIT_OUT), 32'(mb));
    end
    if4.ENABLE = 1'b0;

`ifdef LFSR_GEN_PERIOD_EN
    // 4-bit maximal sequence: WRAP after every 15 advances, counter mod 16.
    RESET = 1'b1; tick(); RESET = 1'b0;
    check("per reset WRAP", 32'(if5.WRAP), 32'h0);
    check("per reset PERIOD_CNT", 32'(if5.PERIOD_CNT), 32'h0);
    if5.ENABLE = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      check($sformatf("per n%0d WRAP", n), 32'(if5.WRAP), (n % 15 == 0) ? 32'h1 : 32'h0);
      check($sformatf("per n%0d PERIOD_CNT", n), 32'(if5.PERIOD_CNT), 32'(n % 16));
    end
    if5.ENABLE = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
